uart_tx_engine: RTL and testbench

Transmit half of the full UART: accepts a byte written by the TramelBlaze over the port bus and serializes it onto `TX`. Frame format is 1 start bit, 7 or 8 data bits LSB first, optional parity, and stop bits. The bit time comes from the baud decoder's `k` count. `TXRDY` is the readable status bit and the source of the transmit interrupt; `UART_Top` edge-detects it.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_engine.sv | 126 ++++++++++++
 tb/tb_uart_tx_engine.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, TX state encoding, parity modes.
// Used by both the transmit and receive engines.
package uart_pkg;

    localparam int K_WIDTH    = 19;
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity over the data bits actually sent; bit 7 is excluded in 7-bit mode.
    function automatic logic calc_parity(input logic [7:0] d, input logic eight, input logic odd);
        logic [7:0] bits;
        bits = eight ? d : {1'b0, d[6:0]};
        return (^bits) ^ (odd == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable k-cycle counter; tick_o pulses on the last cycle of each period.
// load_i restarts the count at load_val_i (receiver uses k/2 for mid-bit sampling).
module uart_bit_timer #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] k_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;

    // k_i is expected to be non-zero; >= keeps a late k change from running away.
    assign wrap   = (cnt_q >= k_i - W'(1));
    assign tick_o = en_i & wrap & ~load_i;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: 1 start, 7/8 data LSB first, optional parity, stop bits, 11 bit-times.
// TXRDY low from the accepting edge until the frame's last bit-time ends; busy writes are dropped.
module uart_tx_engine #(
    parameter int K_WIDTH    = uart_pkg::K_WIDTH,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EIGHT,
    input  logic               PEN,
    input  logic               OHEL,
    input  logic [K_WIDTH-1:0] k,
    input  logic               load,
    input  logic [7:0]         OUT_PORT,
    output logic               TX,
    output logic               TXRDY
);

    import uart_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [7:0]              data_q, data_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [3:0]              bitcnt_q, bitcnt_d;
    logic [K_WIDTH-1:0]      k_q, k_d;
    logic                    tx_q, tx_d;
    logic                    txrdy_q, txrdy_d;
    logic [FRAME_BITS-1:0]   frame;
    logic                    par;
    logic                    tick;

    // Frame image, bit 0 first on the wire; unused slots stay at the stop level.
    always_comb begin
        par       = calc_parity(data_q, EIGHT, OHEL);
        frame     = '1;
        frame[0]  = 1'b0;
        frame[7:1] = data_q[6:0];
        if (EIGHT) begin
            frame[8] = data_q[7];
            if (PEN) begin
                frame[9] = par;
            end
        end else if (PEN) begin
            frame[8] = par;
        end
    end

    uart_bit_timer #(.W(K_WIDTH)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == LOAD),
        .load_val_i ('0),
        .en_i       (state_q == SHIFT),
        .k_i        (k_q),
        .tick_o     (tick)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        k_d      = k_q;
        tx_d     = tx_q;
        txrdy_d  = txrdy_q;
        unique case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                txrdy_d = 1'b1;
                if (load) begin
                    data_d  = OUT_PORT;
                    txrdy_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d  = frame;
                tx_d     = frame[0];
                bitcnt_d = '0;
                k_d      = (k == '0) ? K_WIDTH'(1) : k;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (bitcnt_q == LAST_BIT) begin
                        tx_d     = 1'b1;
                        txrdy_d  = 1'b1;
                        bitcnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        shift_d  = {1'b1, shift_q[FRAME_BITS-1:1]};
                        tx_d     = shift_q[1];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            shift_q  <= '1;
            bitcnt_q <= '0;
            k_q      <= K_WIDTH'(1);
            tx_q     <= 1'b1;
            txrdy_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            k_q      <= k_d;
            tx_q     <= tx_d;
            txrdy_q  <= txrdy_d;
        end
    end

    assign TX    = tx_q;
    assign TXRDY = txrdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: cycle-level waveform model plus literal frame checks.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst, EIGHT, PEN, OHEL, load;
    logic [18:0] k;
    logic [7:0]  OUT_PORT;
    logic        TX, TXRDY;

    int checks = 0;
    int errors = 0;

    uart_tx_engine dut (
        .clk(clk), .rst(rst), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
        .k(k), .load(load), .OUT_PORT(OUT_PORT), .TX(TX), .TXRDY(TXRDY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: the waveform after edge n is a function of the accepting edge t0 and the frame.
    int   n = 0, t0 = 0, kk = 1;
    bit   active = 0, pending = 0, cmp_en = 0, m_prev;
    bit   mframe[11];
    logic [7:0] mdata;

    function automatic bit exp_rdy();
        if (!active) return 1'b1;
        return (n - t0) > 11 * kk;
    endfunction

    function automatic bit exp_tx();
        int d;
        if (!active) return 1'b1;
        d = n - t0;
        if (d >= 1 && d <= 11 * kk) return mframe[(d - 1) / kk];
        return 1'b1;
    endfunction

    function automatic void build_frame(input logic [7:0] dat, input bit e, input bit p, input bit o);
        int nb, ones;
        nb = e ? 8 : 7;
        ones = 0;
        for (int i = 0; i < 11; i++) mframe[i] = 1'b1;
        mframe[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mframe[1 + i] = dat[i];
            ones += int'(dat[i]);
        end
        if (p) mframe[1 + nb] = ((ones % 2) == 1) ^ o;
    endfunction

    always @(posedge clk) begin
        m_prev = exp_rdy();
        n = n + 1;
        if (rst) begin
            active  = 0;
            pending = 0;
        end else if (pending) begin
            build_frame(mdata, EIGHT, PEN, OHEL);
            kk = (k == 0) ? 1 : int'(k);
            pending = 0;
        end else if (load && m_prev) begin
            mdata   = OUT_PORT;
            t0      = n;
            kk      = 1;
            active  = 1;
            pending = 1;
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_tx", TX, exp_tx());
            check("model_txrdy", TXRDY, exp_rdy());
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (TXRDY !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", guard < 5000, 1);
    endtask

    // Caller is at a negedge with TXRDY high; returns at the first negedge TXRDY is high again.
    task automatic directed(input string name, input int kin, input bit e, input bit p, input bit o,
                            input logic [7:0] dat, input logic [0:10] expbits, input int explow,
                            input int busy_at);
        logic [0:10] seen;
        int low, j, kb;
        kb = (kin == 0) ? 1 : kin;
        k = 19'(kin); EIGHT = e; PEN = p; OHEL = o; OUT_PORT = dat; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        seen = '1; low = 0; j = 0;
        check({name, "_e0_tx"}, TX, 1);
        while (TXRDY == 1'b0 && j < 5000) begin
            if (j >= 1 && ((j - 1) % kb) == 0 && ((j - 1) / kb) < 11) seen[(j - 1) / kb] = TX;
            load = (j == busy_at);
            if (j == busy_at) OUT_PORT = 8'hFF;
            low++; j++;
            @(negedge clk);
        end
        load = 1'b0;
        check({name, "_bits"}, 32'(seen), 32'(expbits));
        check({name, "_low"}, low, explow);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; k = 19'd4; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; OUT_PORT = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", TX, 1);
        check("reset_txrdy", TXRDY, 1);
        rst = 1'b0;
        @(negedge clk);

        directed("a5_k4", 4, 1, 1, 0, 8'hA5, 11'b01010010101, 45, -1);
        directed("41_k3", 3, 0, 1, 1, 8'h41, 11'b01000001111, 34, -1);
        directed("busy55", 3, 1, 0, 0, 8'h55, 11'b01010101011, 34, 10);
        @(negedge clk);
        directed("b2b_00", 2, 1, 0, 0, 8'h00, 11'b00000000011, 23, -1);
        check("b2b_gap_pre", TX, 1);
        directed("b2b_ff", 2, 1, 0, 0, 8'hFF, 11'b01111111111, 23, -1);
        directed("80_k0", 0, 1, 0, 0, 8'h80, 11'b00000000111, 12, -1);

        // Reset mid-frame, then a clean frame.
        k = 19'd4; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0; OUT_PORT = 8'hA5; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_busy", TXRDY, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", TX, 1);
        check("midrst_txrdy", TXRDY, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        directed("after_rst", 4, 1, 1, 0, 8'hA5, 11'b01010010101, 45, -1);

        // load and rst on the same edge: reset wins.
        rst = 1'b1; load = 1'b1;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        check("rst_beats_load", TXRDY, 1);
        @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            load     = ($urandom % 4) == 0;
            rst      = ($urandom % 200) == 0;
            OUT_PORT = 8'($urandom);
            EIGHT    = 1'($urandom);
            PEN      = 1'($urandom);
            OHEL     = 1'($urandom);
            k        = 19'($urandom % 6);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
